// File: rtl/eth_key_extract.sv
// rtl/eth_key_extract.sv - IPv4 TCP/UDP flow key extractor on a 64-bit frame stream
// Ports:
//   clk, rst                      clock; synchronous active-high reset
//   s_data, s_keep                frame beat and byte-valid mask (byte i at s_data[8*i+7:8*i])
//   s_valid, s_last               beat valid (always accepted) and end-of-frame marker
//   in_key, in_flag               flow key {src ip, dst ip, src port, dst port}, flags {UDP,RST,FIN,SYN}
//   in_valid                      one-cycle strobe per emitted key
//   cnt_frames/keys/skipped       wrapping statistics counters
module eth_key_extract #(
  parameter int KEY_SIZE = 96
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [63:0]         s_data,
  input  logic [7:0]          s_keep,
  input  logic                s_valid,
  input  logic                s_last,
  output logic [KEY_SIZE-1:0] in_key,
  output logic [3:0]          in_flag,
  output logic                in_valid,
  output logic [31:0]         cnt_frames,
  output logic [31:0]         cnt_keys,
  output logic [31:0]         cnt_skipped
);

  typedef enum logic [1:0] {ST_IDLE, ST_PARSE, ST_DONE} state_e;

  state_e              state_q, state_d;
  logic [2:0]          beat_q, beat_d;
  logic                udp_q, udp_d;
  logic                emitted_q, emitted_d;
  logic [KEY_SIZE-1:0] part_q, part_d;
  logic [KEY_SIZE-1:0] key_q;
  logic [3:0]          flag_q;
  logic                valid_q;
  logic [31:0]         frames_q, keys_q, skipped_q;

  logic [7:0]          b [8];
  logic                emit;
  logic                frame_end;
  logic [KEY_SIZE-1:0] key_new;
  logic [3:0]          flag_new;

  always_comb begin
    for (int i = 0; i < 8; i++) begin
      b[i] = s_data[8*i +: 8];
    end
  end

  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    udp_d     = udp_q;
    emitted_d = emitted_q;
    part_d    = part_q;
    emit      = 1'b0;
    key_new   = part_q;
    flag_new  = 4'b0000;
    frame_end = 1'b0;

    if (s_valid) begin
      beat_d = (beat_q == 3'd6) ? 3'd6 : beat_q + 3'd1;
      case (state_q)
        ST_IDLE: state_d = ST_PARSE;
        ST_PARSE: begin
          case (beat_q)
            // ethertype 0x0800 and version/IHL 0x45 (untagged, no options)
            3'd1: begin
              if (!(b[4] == 8'h08 && b[5] == 8'h00 && b[6] == 8'h45)) state_d = ST_DONE;
            end
            // protocol TCP/UDP, and no fragment offset or MF bit (DF is allowed)
            3'd2: begin
              udp_d = (b[7] == 8'd17);
              if (!(b[7] == 8'd6 || b[7] == 8'd17) || ((b[4] & 8'h3F) | b[5]) != 8'h00)
                state_d = ST_DONE;
            end
            3'd3: part_d[95:48] = {b[2], b[3], b[4], b[5], b[6], b[7]};
            3'd4: begin
              part_d[47:0] = {b[0], b[1], b[2], b[3], b[4], b[5]};
              if (udp_q) begin
                state_d = ST_DONE;
                if ((s_keep & 8'h20) != 8'h00) begin
                  emit     = 1'b1;
                  key_new  = {part_q[95:48], b[0], b[1], b[2], b[3], b[4], b[5]};
                  flag_new = 4'b1000;
                end
              end
            end
            // TCP flags byte: wire bit1 SYN, bit0 FIN, bit2 RST
            3'd5: begin
              state_d = ST_DONE;
              if ((s_keep & 8'h80) != 8'h00) begin
                emit     = 1'b1;
                key_new  = part_q;
                flag_new = {1'b0, b[7][2], b[7][0], b[7][1]};
              end
            end
            default: state_d = ST_DONE;
          endcase
        end
        default: ;
      endcase

      if (emit) emitted_d = 1'b1;

      if (s_last) begin
        state_d   = ST_IDLE;
        beat_d    = 3'd0;
        emitted_d = 1'b0;
        frame_end = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      beat_q    <= 3'd0;
      udp_q     <= 1'b0;
      emitted_q <= 1'b0;
      part_q    <= '0;
      key_q     <= '0;
      flag_q    <= 4'b0000;
      valid_q   <= 1'b0;
      frames_q  <= 32'd0;
      keys_q    <= 32'd0;
      skipped_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      udp_q     <= udp_d;
      emitted_q <= emitted_d;
      part_q    <= part_d;
      valid_q   <= emit;
      if (emit) begin
        key_q  <= key_new;
        flag_q <= flag_new;
        keys_q <= keys_q + 32'd1;
      end
      if (frame_end) frames_q <= frames_q + 32'd1;
      // a frame whose emitting beat is also its last beat is not skipped
      if (frame_end && !emitted_q && !emit) skipped_q <= skipped_q + 32'd1;
    end
  end

  assign in_key      = key_q;
  assign in_flag     = flag_q;
  assign in_valid    = valid_q;
  assign cnt_frames  = frames_q;
  assign cnt_keys    = keys_q;
  assign cnt_skipped = skipped_q;

endmodule

// File: tb/tb_eth_key_extract.sv
// tb/tb_eth_key_extract.sv - directed and randomized self-checking bench for eth_key_extract
module tb_eth_key_extract;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] s_data;
  logic [7:0]  s_keep;
  logic        s_valid;
  logic        s_last;
  logic [95:0] in_key;
  logic [3:0]  in_flag;
  logic        in_valid;
  logic [31:0] cnt_frames, cnt_keys, cnt_skipped;

  always #5 clk = ~clk;

  eth_key_extract #(.KEY_SIZE(96)) dut (
    .clk(clk), .rst(rst), .s_data(s_data), .s_keep(s_keep), .s_valid(s_valid), .s_last(s_last),
    .in_key(in_key), .in_flag(in_flag), .in_valid(in_valid),
    .cnt_frames(cnt_frames), .cnt_keys(cnt_keys), .cnt_skipped(cnt_skipped)
  );

  int n_assert = 0;
  int n_fail   = 0;
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // current frame, and the frame-level reference results for it
  logic [7:0]  frm [$];
  bit          m_emit;
  int          m_beat;
  logic [95:0] m_key;
  logic [3:0]  m_flag;
  int unsigned m_frames, m_keys, m_skipped;
  logic [95:0] last_key;
  logic [3:0]  last_flag;

  int unsigned exp_cyc [$];
  logic [95:0] exp_key [$];
  logic [3:0]  exp_flag [$];
  int unsigned obs_cyc [$];
  logic [95:0] obs_key [$];
  logic [3:0]  obs_flag [$];

  always @(negedge clk) begin
    if (in_valid) begin
      obs_cyc.push_back(cyc);
      obs_key.push_back(in_key);
      obs_flag.push_back(in_flag);
    end
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] fb(input int i);
    return (i < frm.size()) ? frm[i] : 8'h00;
  endfunction

  function automatic void put(input int i, input logic [7:0] v);
    if (i < frm.size()) frm[i] = v;
  endfunction

  // Frame-level decision: header fields must match and the frame must be long
  // enough to contain the last byte the key/flags depend on.
  task automatic model();
    int len;
    logic [7:0] tf;
    len = frm.size();
    m_emit = 1'b0; m_beat = -1; m_key = '0; m_flag = 4'b0000;
    for (int i = 0; i < 12; i++) m_key = {m_key[87:0], fb(26 + i)};
    tf = fb(47);
    if ({fb(12), fb(13)} == 16'h0800 && fb(14) == 8'h45 && ({fb(20), fb(21)} & 16'h3FFF) == 16'h0) begin
      if (fb(23) == 8'd17 && len >= 38) begin
        m_emit = 1'b1; m_beat = 4; m_flag = 4'b1000;
      end else if (fb(23) == 8'd6 && len >= 48) begin
        m_emit = 1'b1; m_beat = 5; m_flag = {1'b0, tf[2], tf[0], tf[1]};
      end
    end
  endtask

  task automatic build(input int len, input logic [15:0] etype, input logic [7:0] vihl,
                       input logic [15:0] frag, input logic [7:0] proto,
                       input logic [31:0] sip, input logic [31:0] dip,
                       input logic [15:0] sp, input logic [15:0] dp, input logic [7:0] tflags);
    logic [95:0] k;
    k = {sip, dip, sp, dp};
    frm.delete();
    for (int i = 0; i < len; i++) frm.push_back(8'($urandom));
    put(12, etype[15:8]); put(13, etype[7:0]); put(14, vihl);
    put(20, frag[15:8]);  put(21, frag[7:0]);  put(23, proto);
    for (int i = 0; i < 12; i++) put(26 + i, k[95 - 8*i -: 8]);
    put(47, tflags);
  endtask

  // Drives the frame in frm; gap idle cycles between beats; rst_beat >= 0 resets on that beat.
  task automatic send(input int gap, input int rst_beat);
    int nb;
    int unsigned dcyc;
    model();
    nb = (frm.size() + 7) / 8;
    dcyc = 0;
    for (int k = 0; k < nb; k++) begin
      s_valid = 1'b1;
      s_last  = (k == nb - 1);
      for (int j = 0; j < 8; j++) begin
        s_data[8*j +: 8] = fb(8*k + j);
        s_keep[j]        = (8*k + j < frm.size());
      end
      rst = (k == rst_beat);
      if (k == m_beat) dcyc = cyc;
      @(posedge clk); #1;
      s_valid = 1'b0;
      s_data  = {$urandom, $urandom};
      s_last  = 1'($urandom_range(0, 1));
      if (k == rst_beat) begin
        rst = 1'b0;
        m_frames = 0; m_keys = 0; m_skipped = 0;
        last_key = '0; last_flag = 4'b0000;
        return;
      end
      if (k < nb - 1) begin
        repeat (gap) begin
          s_data = {$urandom, $urandom};
          @(posedge clk); #1;
        end
      end
    end
    m_frames++;
    if (m_emit) begin
      m_keys++;
      exp_cyc.push_back(dcyc + 1);
      exp_key.push_back(m_key);
      exp_flag.push_back(m_flag);
      last_key = m_key; last_flag = m_flag;
    end else begin
      m_skipped++;
    end
  endtask

  task automatic settle(input string tag);
    int n;
    repeat (8) @(posedge clk);
    @(negedge clk);
    check({tag, "_npulse"}, 128'(obs_cyc.size()), 128'(exp_cyc.size()));
    n = (obs_cyc.size() < exp_cyc.size()) ? obs_cyc.size() : exp_cyc.size();
    for (int i = 0; i < n; i++) begin
      check({tag, "_pulse_cycle"}, 128'(obs_cyc[i]), 128'(exp_cyc[i]));
      check({tag, "_pulse_key"},   128'(obs_key[i]), 128'(exp_key[i]));
      check({tag, "_pulse_flag"},  128'(obs_flag[i]), 128'(exp_flag[i]));
    end
    check({tag, "_cnt_frames"},  128'(cnt_frames),  128'(m_frames));
    check({tag, "_cnt_keys"},    128'(cnt_keys),    128'(m_keys));
    check({tag, "_cnt_skipped"}, 128'(cnt_skipped), 128'(m_skipped));
    check({tag, "_key_hold"},    128'(in_key),      128'(last_key));
    check({tag, "_flag_hold"},   128'(in_flag),     128'(last_flag));
    exp_cyc.delete(); exp_key.delete(); exp_flag.delete();
    obs_cyc.delete(); obs_key.delete(); obs_flag.delete();
    @(posedge clk); #1;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_valid"},   128'(in_valid),    128'(0));
    check({tag, "_key"},     128'(in_key),      128'(0));
    check({tag, "_flag"},    128'(in_flag),     128'(0));
    check({tag, "_frames"},  128'(cnt_frames),  128'(0));
    check({tag, "_keys"},    128'(cnt_keys),    128'(0));
    check({tag, "_skipped"}, 128'(cnt_skipped), 128'(0));
  endtask

  initial begin
    logic [15:0] et, fr;
    logic [7:0]  vi, pr;
    int          gp;

    rst = 1'b1; s_valid = 1'b0; s_last = 1'b0; s_data = '0; s_keep = '0;
    m_frames = 0; m_keys = 0; m_skipped = 0; last_key = '0; last_flag = 4'b0000;
    repeat (3) @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_zero("reset");
    @(posedge clk); #1;

    // TCP SYN 10.0.0.1:1234 -> 10.0.0.2:80, 64 bytes
    build(64, 16'h0800, 8'h45, 16'h0000, 8'd6, 32'h0A000001, 32'h0A000002, 16'd1234, 16'd80, 8'h02);
    send(0, -1);
    settle("tcp_syn");
    check("tcp_syn_key_const",  128'(in_key),  128'(96'h0A000001_0A000002_04D2_0050));
    check("tcp_syn_flag_const", 128'(in_flag), 128'(4'b0001));

    // UDP 192.168.1.1:53 -> 192.168.1.2:5000, 60 bytes
    build(60, 16'h0800, 8'h45, 16'h0000, 8'd17, 32'hC0A80101, 32'hC0A80102, 16'd53, 16'd5000, 8'h00);
    send(0, -1);
    settle("udp");
    check("udp_key_const",  128'(in_key),  128'(96'hC0A80101_C0A80102_0035_1388));
    check("udp_flag_const", 128'(in_flag), 128'(4'b1000));

    // ARP, IHL 6, ICMP: all skipped
    build(64, 16'h0806, 8'h45, 16'h0000, 8'd6, 32'h01020304, 32'h05060708, 16'd1, 16'd2, 8'h02);
    send(0, -1);
    build(64, 16'h0800, 8'h46, 16'h0000, 8'd6, 32'h01020304, 32'h05060708, 16'd1, 16'd2, 8'h02);
    send(0, -1);
    build(64, 16'h0800, 8'h45, 16'h0000, 8'd1, 32'h01020304, 32'h05060708, 16'd1, 16'd2, 8'h02);
    send(0, -1);
    settle("reject");
    check("reject_skipped_const", 128'(cnt_skipped), 128'(3));

    // TCP truncated on beat 4, then the SYN frame with 3 idle cycles between beats
    build(40, 16'h0800, 8'h45, 16'h0000, 8'd6, 32'h0A000001, 32'h0A000002, 16'd1234, 16'd80, 8'h02);
    send(0, -1);
    build(64, 16'h0800, 8'h45, 16'h0000, 8'd6, 32'h0A000001, 32'h0A000002, 16'd1234, 16'd80, 8'h02);
    send(3, -1);
    settle("gapped");
    check("gapped_key_const", 128'(in_key), 128'(96'h0A000001_0A000002_04D2_0050));

    // Back-to-back: TCP with byte 47 = 0x05 (FIN and RST) then UDP
    build(64, 16'h0800, 8'h45, 16'h0000, 8'd6, 32'h0A000001, 32'h0A000002, 16'd1234, 16'd80, 8'h05);
    send(0, -1);
    build(60, 16'h0800, 8'h45, 16'h0000, 8'd17, 32'hC0A80101, 32'hC0A80102, 16'd53, 16'd5000, 8'h00);
    send(0, -1);
    settle("b2b");

    // Reset on beat 3 of a TCP frame, then a full UDP frame
    build(64, 16'h0800, 8'h45, 16'h0000, 8'd6, 32'h0A000001, 32'h0A000002, 16'd1234, 16'd80, 8'h02);
    send(0, 3);
    @(negedge clk);
    check_zero("midrst");
    @(posedge clk); #1;
    build(60, 16'h0800, 8'h45, 16'h0000, 8'd17, 32'hC0A80101, 32'hC0A80102, 16'd53, 16'd5000, 8'h00);
    send(0, -1);
    settle("after_rst");
    check("after_rst_frames_const", 128'(cnt_frames), 128'(1));

    // Randomized frames with occasional gaps and varied headers/lengths
    for (int f = 0; f < 80; f++) begin
      et = ($urandom_range(0, 7) != 0) ? 16'h0800 : 16'($urandom);
      vi = ($urandom_range(0, 7) != 0) ? 8'h45 : 8'($urandom);
      case ($urandom_range(0, 7))
        0:       fr = 16'($urandom);
        1:       fr = 16'h4000;
        2:       fr = 16'h2000;
        default: fr = 16'h0000;
      endcase
      case ($urandom_range(0, 5))
        0, 1:    pr = 8'd6;
        2, 3:    pr = 8'd17;
        4:       pr = 8'd1;
        default: pr = 8'($urandom);
      endcase
      gp = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
      build($urandom_range(1, 96), et, vi, fr, pr, $urandom, $urandom,
            16'($urandom), 16'($urandom), 8'($urandom));
      send(gp, -1);
      if (f % 10 == 9) settle("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
